// File: rtl/qpsk_sp_mapper_if.sv
// Bit-stream handshake and mapped I/Q symbol bundle for the QPSK splitter/mapper.
// master drives the serial bits; slave is the mapper.
interface qpsk_sp_mapper_if;
  logic       bit_in;
  logic       bit_valid;
  logic       bit_ready;
  logic [1:0] I_out;
  logic [1:0] Q_out;
  logic       sym_strobe;
  logic       underrun;

  modport master (
    output bit_in, bit_valid,
    input  bit_ready, I_out, Q_out, sym_strobe, underrun
  );

  modport slave (
    input  bit_in, bit_valid,
    output bit_ready, I_out, Q_out, sym_strobe, underrun
  );
endinterface

// File: rtl/qpsk_sp_mapper.sv
// QPSK transmit splitter/mapper: pairs serial bits as (I, Q), buffers one symbol,
// and emits mapped bipolar levels on a free-running SYM_DIV-cycle symbol tick.
module qpsk_sp_mapper #(
  parameter int unsigned SYM_DIV = 4,
  parameter logic [1:0]  MAP_POS = 2'b01,
  parameter logic [1:0]  MAP_NEG = 2'b11
) (
  input  logic              clk_fs,
  input  logic              rst_n,
  qpsk_sp_mapper_if.slave   bus
);

  typedef enum logic {StIbit, StQbit} phase_e;

  phase_e     phase_q, phase_d;
  logic       i_bit_q, i_bit_d;
  logic [1:0] pending_q, pending_d;
  logic       pending_full_q, pending_full_d;
  logic [3:0] sym_cnt_q, sym_cnt_d;
  logic [1:0] i_out_q, i_out_d;
  logic [1:0] q_out_q, q_out_d;
  logic       strobe_q, strobe_d;
  logic       underrun_q, underrun_d;

  logic ready;
  logic xfer;
  logic tick;

  function automatic logic [1:0] map_bit(input logic b);
    return b ? MAP_NEG : MAP_POS;
  endfunction

  // Refuse only the Q bit while the buffer is full, so a pair can never overwrite it.
  assign ready = ~(pending_full_q & (phase_q == StQbit));
  assign xfer  = bus.bit_valid & ready;
  assign tick  = (sym_cnt_q == 4'(SYM_DIV - 1));

  always_comb begin
    phase_d        = phase_q;
    i_bit_d        = i_bit_q;
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    sym_cnt_d      = tick ? 4'd0 : sym_cnt_q + 4'd1;
    i_out_d        = i_out_q;
    q_out_d        = q_out_q;
    strobe_d       = 1'b0;
    underrun_d     = 1'b0;

    // Tick consumes the buffer before the assembler can refill it: no bypass.
    if (tick) begin
      strobe_d = 1'b1;
      if (pending_full_q) begin
        i_out_d        = map_bit(pending_q[1]);
        q_out_d        = map_bit(pending_q[0]);
        pending_full_d = 1'b0;
      end else begin
        i_out_d    = 2'b00;
        q_out_d    = 2'b00;
        underrun_d = 1'b1;
      end
    end

    if (xfer) begin
      unique case (phase_q)
        StIbit: begin
          i_bit_d = bus.bit_in;
          phase_d = StQbit;
        end
        StQbit: begin
          pending_d      = {i_bit_q, bus.bit_in};
          pending_full_d = 1'b1;
          phase_d        = StIbit;
        end
        default: phase_d = StIbit;
      endcase
    end
  end

  always_ff @(posedge clk_fs or negedge rst_n) begin
    if (!rst_n) begin
      phase_q        <= StIbit;
      i_bit_q        <= 1'b0;
      pending_q      <= 2'b00;
      pending_full_q <= 1'b0;
      sym_cnt_q      <= 4'd0;
      i_out_q        <= 2'b00;
      q_out_q        <= 2'b00;
      strobe_q       <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      phase_q        <= phase_d;
      i_bit_q        <= i_bit_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      sym_cnt_q      <= sym_cnt_d;
      i_out_q        <= i_out_d;
      q_out_q        <= q_out_d;
      strobe_q       <= strobe_d;
      underrun_q     <= underrun_d;
    end
  end

  assign bus.bit_ready  = ready;
  assign bus.I_out      = i_out_q;
  assign bus.Q_out      = q_out_q;
  assign bus.sym_strobe = strobe_q;
  assign bus.underrun   = underrun_q;

endmodule

// File: doc/qpsk_sp_mapper.md
Name: qpsk_sp_mapper

Overview:
Transmit-side QPSK serial-to-parallel splitter and mapper, the modulator counterpart of the demodulator's I/Q-to-serial stage. It accepts a serial bit stream through a valid/ready handshake and pairs bits as (I, Q), first bit to I. Each pair is mapped to 2-bit bipolar levels and presented to the I/Q shaping filters, one symbol every SYM_DIV clocks. A one-symbol buffer decouples the bit source from the symbol timer.

Parameters:
SYM_DIV, 4, clk_fs cycles per symbol; legal range 2..16; counter width 4 bits.
MAP_POS, 2'b01, level driven for bit 0 (+1, two's complement).
MAP_NEG, 2'b11, level driven for bit 1 (-1, two's complement).

Ports:
clk_fs  input  1  system clock (10 MHz).
rst_n  input  1  asynchronous active-low reset.
bit_in  input  1  serial data bit.
bit_valid  input  1  bit_in is valid this cycle.
bit_ready  output  1  block can accept bit_in this cycle; transfer occurs when bit_valid & bit_ready.
I_out  output  2  mapped I level, two's complement.
Q_out  output  2  mapped Q level, two's complement.
sym_strobe  output  1  one-cycle pulse when I_out/Q_out update.
underrun  output  1  one-cycle pulse when a symbol slot finds no data.

Behaviour:
Reset (async on rst_n low, all registers):
- I_out = Q_out = 2'b00; sym_strobe = 0; underrun = 0.
- phase = 0; pending_full = 0; sym_cnt = 0.
- bit_ready = 1 on release.
- Reset mid-symbol discards any half-assembled pair and any pending pair; no strobe is emitted.

Assembler:
- phase = 0 means expecting the I bit; phase = 1 means expecting the Q bit.
- On transfer with phase = 0: latch i_bit <= bit_in; phase <= 1.
- On transfer with phase = 1: pending <= {i_bit, bit_in}; pending_full <= 1; phase <= 0.
- No transfer: assembler holds its state indefinitely. Gaps between the I and Q bits are allowed.

Flow control:
- bit_ready = ~(pending_full & phase), combinational from registers only; no combinational path from bit_valid.
- The I bit may always be accepted. The Q bit is refused while the buffer is full.
- A pair therefore never completes while pending_full = 1, so no overwrite is possible.

Symbol timer:
- sym_cnt counts 0..SYM_DIV-1 and wraps. A tick occurs in the cycle where sym_cnt == SYM_DIV-1.
- It free-runs from reset, independent of data.

On a tick edge:
- If pending_full = 1:
  - I_out <= map(pending[1]); Q_out <= map(pending[0]).
  - sym_strobe <= 1; pending_full <= 0.
- If pending_full = 0:
  - I_out <= 2'b00; Q_out <= 2'b00 (idle, zero carrier).
  - sym_strobe <= 1; underrun <= 1.
- sym_strobe and underrun are 0 on every other cycle.
- map(b) = b ? MAP_NEG : MAP_POS.

Tick coinciding with a Q-bit transfer:
- Occurs only when pending_full = 0. The buffer is empty, so the tick emits idle plus underrun.
- The new pair enters pending and is emitted on the next tick.
- There is no same-cycle bypass.

Tick while pending_full = 1 and phase = 1:
- bit_ready rises the cycle after the tick.

Latency:
- The pair completes at edge k. Outputs update at the first tick edge strictly after k.
- Maximum latency is SYM_DIV cycles.

Outputs:
- I_out and Q_out are held constant between strobes.
- Sustained throughput is 2 bits per SYM_DIV cycles. A source providing at least that rate never causes underrun after the first symbol.

Test Plan:
- Reset then idle, SYM_DIV = 4, bit_valid = 0 for 12 cycles:
  - sym_strobe and underrun pulse at cycles 3, 7, 11.
  - I_out = Q_out = 00 throughout; bit_ready = 1.
- Feed bits 0,1 back-to-back, then hold bit_valid = 0:
  - The next tick gives I_out = 01, Q_out = 11, sym_strobe = 1, underrun = 0.
  - The following tick gives 00/00 with underrun.
- Continuous bit_valid = 1 with pattern 1,1,0,0,1,0,0,1:
  - bit_ready deasserts while the buffer is full and the Q bit is pending.
  - Symbols emitted in order: (11,11), (01,01), (11,01), (01,11).
  - No underrun after the first symbol; no bit lost or duplicated (scoreboard against the input queue).
- I bit accepted, 10-cycle gap, then Q bit:
  - Pair assembled correctly; the interim ticks show underrun.
  - Symbol equals {I, Q} of the two bits.
- Q-bit transfer in the same cycle as a tick with the buffer empty:
  - That tick emits idle plus underrun.
  - The pair appears exactly SYM_DIV cycles later.
- Assert rst_n low asynchronously mid-cycle with phase = 1 and pending_full = 1:
  - All outputs are 0 immediately.
  - After release, the first valid bit is treated as an I bit and the stale pair is never emitted.
